// File: rtl/alarm_siren_ctrl_if.sv
// Annunciator bus between the security-alarm FSM (master) and the siren
// output stage (slave).
// alarm_in/ack are levels sampled on every clk edge; there is no valid/ready
// pairing. siren/strobe/status/remain are registered and valid every cycle.
interface alarm_siren_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             alarm_in;
    logic             ack;
    logic             siren;
    logic             strobe;
    logic [1:0]       status;
    logic [CNT_W-1:0] remain;

    modport master (
        output alarm_in, ack,
        input  siren, strobe, status, remain
    );

    modport slave (
        input  alarm_in, ack,
        output siren, strobe, status, remain
    );
endinterface

// File: rtl/alarm_siren_ctrl.sv
// Siren/strobe output stage behind the security-alarm FSM: grace period,
// tone, strobe, auto-silence and acknowledge. Define ALARM_SIREN_LATCH_EN to
// keep SOUNDING latched after alarm_in drops (only ack/timeout exit it).
module alarm_siren_ctrl #(
    parameter int TICK_DIV    = 1000,
    parameter int ENTRY_TICKS = 10,
    parameter int SIREN_TICKS = 60,
    parameter int TONE_DIV    = 250,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alarm_siren_ctrl_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    // Encoding doubles as the status output.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_GRACE    = 2'b01,
        ST_SOUNDING = 2'b10,
        ST_SILENCED = 2'b11
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] remain, remain_nx;
    logic [PW-1:0]    presc, presc_nx;
    logic [TW-1:0]    tone, tone_nx;
    logic             siren, siren_nx;
    logic             strobe, strobe_nx;
    logic             tick;
    logic             last_tick;

    assign tick      = (presc == PW'(TICK_DIV - 1));
    assign last_tick = tick && (remain == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            remain <= '0;
            presc  <= '0;
            tone   <= '0;
            siren  <= 1'b0;
            strobe <= 1'b0;
        end else begin
            state  <= state_nx;
            remain <= remain_nx;
            presc  <= presc_nx;
            tone   <= tone_nx;
            siren  <= siren_nx;
            strobe <= strobe_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        remain_nx = remain;
        presc_nx  = tick ? '0 : presc + 1'b1;
        tone_nx   = '0;
        siren_nx  = 1'b0;
        strobe_nx = strobe;

        // Priority: alarm drop, then ack, then timeout.
        case (state)
            ST_IDLE: begin
                if (bus.alarm_in)
                    state_nx = (ENTRY_TICKS == 0) ? ST_SOUNDING : ST_GRACE;
            end
            ST_GRACE: begin
                if (!bus.alarm_in)  state_nx = ST_IDLE;
                else if (bus.ack)   state_nx = ST_SILENCED;
                else if (last_tick) state_nx = ST_SOUNDING;
            end
            ST_SOUNDING: begin
`ifdef ALARM_SIREN_LATCH_EN
                if (bus.ack)        state_nx = ST_SILENCED;
                else if (last_tick) state_nx = ST_SILENCED;
`else
                if (!bus.alarm_in)  state_nx = ST_IDLE;
                else if (bus.ack)   state_nx = ST_SILENCED;
                else if (last_tick) state_nx = ST_SILENCED;
`endif
            end
            ST_SILENCED: begin
                if (!bus.alarm_in)  state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        if (state_nx != state) begin
            // Restart the prescaler so the new state's first tick is full length.
            presc_nx = '0;
            case (state_nx)
                ST_GRACE: begin
                    remain_nx = CNT_W'(ENTRY_TICKS);
                    strobe_nx = 1'b1;
                end
                ST_SOUNDING: begin
                    remain_nx = CNT_W'(SIREN_TICKS);
                    strobe_nx = 1'b1;
                    siren_nx  = 1'b1;
                end
                default: begin
                    remain_nx = '0;
                    strobe_nx = 1'b0;
                end
            endcase
        end else begin
            case (state)
                ST_GRACE: begin
                    if (tick) begin
                        if (remain != '0) remain_nx = remain - 1'b1;
                        strobe_nx = ~strobe;
                    end
                end
                ST_SOUNDING: begin
                    if (tick && remain != '0) remain_nx = remain - 1'b1;
                    siren_nx = siren;
                    if (tone == TW'(TONE_DIV - 1)) begin
                        siren_nx = ~siren;
                        tone_nx  = '0;
                    end else begin
                        tone_nx  = tone + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.status = state;
    assign bus.remain = remain;
    assign bus.siren  = siren;
    assign bus.strobe = strobe;
endmodule

// File: tb/tb_alarm_siren_ctrl.sv
// Directed bench for alarm_siren_ctrl with TICK_DIV=4, ENTRY_TICKS=3,
// SIREN_TICKS=5, TONE_DIV=2; latch-mode expectations follow ALARM_SIREN_LATCH_EN.
module tb_alarm_siren_ctrl;
    localparam int TICK_DIV    = 4;
    localparam int ENTRY_TICKS = 3;
    localparam int SIREN_TICKS = 5;
    localparam int TONE_DIV    = 2;
    localparam int CNT_W       = 8;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [0:0] exp_q[$];

    alarm_siren_ctrl_if #(.CNT_W(CNT_W)) bus ();

    alarm_siren_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .ENTRY_TICKS(ENTRY_TICKS),
        .SIREN_TICKS(SIREN_TICKS),
        .TONE_DIV   (TONE_DIV),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input int rem,
                             input logic sir, input logic strb);
        check({tag, ".status"}, 32'(bus.status), 32'(st));
        check({tag, ".remain"}, 32'(bus.remain), 32'(rem));
        check({tag, ".siren"},  32'(bus.siren),  32'(sir));
        check({tag, ".strobe"}, 32'(bus.strobe), 32'(strb));
    endtask

    // Advance one edge and land 1 ns after it, where outputs are sampled and inputs driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus.alarm_in = 1'b0;
        bus.ack      = 1'b0;

        // Reset held while inputs wiggle
        for (int i = 0; i < 4; i++) begin
            bus.alarm_in = i[0];
            bus.ack      = i[1];
            step();
            check_all("reset_hold", 2'b00, 0, 1'b0, 1'b0);
        end
        bus.alarm_in = 1'b0;
        bus.ack      = 1'b0;
        rst_n = 1'b1;
        step_n(2);
        check_all("idle", 2'b00, 0, 1'b0, 1'b0);

        // Grace period: edge N enters GRACE, edge N+12 enters SOUNDING
        bus.alarm_in = 1'b1;
        step();
        check_all("grace_entry", 2'b01, 3, 1'b0, 1'b1);
        for (int k = 1; k < 12; k++) begin
            step();
            check_all("grace", 2'b01, 3 - k / 4, 1'b0, ((k / 4) % 2) == 0);
        end
        step();
        check_all("sound_entry", 2'b10, 5, 1'b1, 1'b1);

        // Sounding: siren period 4 clks, remain drops every 4, silence at M+20
        for (int j = 1; j < 20; j++) exp_q.push_back(((j / 2) % 2) == 0);
        for (int j = 1; j < 20; j++) begin
            step();
            check("sound.status", 32'(bus.status), 32'd2);
            check("sound.remain", 32'(bus.remain), 32'(5 - j / 4));
            check("sound.strobe", 32'(bus.strobe), 32'd1);
            check("sound.siren",  32'(bus.siren),  32'(exp_q.pop_front()));
        end
        step();
        check_all("timeout_silenced", 2'b11, 0, 1'b0, 1'b0);
        step_n(3);
        check_all("silenced_hold", 2'b11, 0, 1'b0, 1'b0);
        bus.alarm_in = 1'b0;
        step();
        check_all("silenced_to_idle", 2'b00, 0, 1'b0, 1'b0);

        // ack in GRACE at remain=2
        bus.alarm_in = 1'b1;
        step();
        check_all("grace2_entry", 2'b01, 3, 1'b0, 1'b1);
        step_n(4);
        check_all("grace2_rem2", 2'b01, 2, 1'b0, 1'b0);
        bus.ack = 1'b1;
        step();
        check_all("ack_grace", 2'b11, 0, 1'b0, 1'b0);
        bus.ack = 1'b0;
        step_n(2);
        check("no_retrigger", 32'(bus.status), 32'd3);
        bus.alarm_in = 1'b0;
        step();
        check("ack_then_idle", 32'(bus.status), 32'd0);

        // ack together with alarm drop: alarm drop wins
        bus.alarm_in = 1'b1;
        step();
        check("grace3_entry", 32'(bus.status), 32'd1);
        bus.alarm_in = 1'b0;
        bus.ack      = 1'b1;
        step();
        check_all("ack_vs_drop", 2'b00, 0, 1'b0, 1'b0);
        bus.ack = 1'b0;

        // Asynchronous reset in the middle of SOUNDING
        bus.alarm_in = 1'b1;
        step_n(13);
        check("sound2_entry", 32'(bus.status), 32'd2);
        step();
        #2 rst_n = 1'b0;
        #1;
        check_all("async_reset", 2'b00, 0, 1'b0, 1'b0);
        step();
        check_all("reset_low", 2'b00, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check_all("post_reset_grace", 2'b01, 3, 1'b0, 1'b1);

        // alarm drop while SOUNDING
        step_n(12);
        check("sound3_entry", 32'(bus.status), 32'd2);
        bus.alarm_in = 1'b0;
        step();
`ifdef ALARM_SIREN_LATCH_EN
        check("latch_hold", 32'(bus.status), 32'd2);
        step_n(3);
        check("latch_hold2", 32'(bus.status), 32'd2);
        bus.ack = 1'b1;
        step();
        check_all("latch_ack", 2'b11, 0, 1'b0, 1'b0);
        bus.ack = 1'b0;
        step();
        check_all("latch_to_idle", 2'b00, 0, 1'b0, 1'b0);
`else
        check_all("drop_sound", 2'b00, 0, 1'b0, 1'b0);
        step_n(2);
        check("drop_idle_hold", 32'(bus.status), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
